// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Optional hold timeout is enabled by defining ARB_HOLD_TIMEOUT_EN.
package mux_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int N_DEF = 4;
    localparam int SEL_W = $clog2(N_DEF);

    function automatic logic [31:0] onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req&mask
// scanning from ptr upward, wrapping at N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic [N-1:0]         mask,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int SW = $clog2(N);

    logic [N-1:0]  cand;
    logic [SW-1:0] j;

    assign cand = req & mask;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = ptr + SW'(i);
            if (!found && cand[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of an N:1 one-bit mux.
// Define ARB_HOLD_TIMEOUT_EN to bound how long one grant may be held.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         a,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] s,
    output logic                 busy,
    output logic                 out
);

    localparam int SW = $clog2(N);

    arb_state_t    state;
    logic [SW-1:0] ptr;
    logic          found;
    logic [SW-1:0] idx;
    logic          keep;

    // The current owner is masked so a preempted requester re-competes last.
    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .mask  (~grant),
        .found (found),
        .idx   (idx)
    );

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_cnt;
    logic          others;
    logic          timeout;

    assign others  = |(req & ~grant);
    assign timeout = (hold_cnt == HW'(MAX_HOLD - 1)) && others;
    assign keep    = req[s] && !timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == GRANT && keep) begin
            if (hold_cnt != HW'(MAX_HOLD - 1))
                hold_cnt <= hold_cnt + 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end
`else
    assign keep = req[s];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            s     <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        grant <= N'(onehot(32'(idx)));
                        s     <= idx;
                        busy  <= 1'b1;
                        ptr   <= idx + 1'b1;
                    end
                end
                GRANT: begin
                    if (keep) begin
                        state <= GRANT;
                    end else if (found) begin
                        grant <= N'(onehot(32'(idx)));
                        s     <= idx;
                        ptr   <= idx + 1'b1;
                    end else begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out = busy & a[s];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed table, corner
// sequences and randomized traffic against a queue-free reference model.
module tb_mux_rr_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] grant;
    logic [1:0] s;
    logic       busy;
    logic       out;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_g;
    int m_s;
    int m_ptr;
    int m_hold;

    mux_rr_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .a     (a),
        .grant (grant),
        .s     (s),
        .busy  (busy),
        .out   (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] a;
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       o;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: serve owner while it requests (unless timed out), otherwise
    // hand over to the nearest pending requester from the pointer.
    task automatic model_step(input logic r, input logic [3:0] rq);
        bit keep;
        bit others;
        int w;
        if (r) begin
            m_g = -1; m_s = 0; m_ptr = 0; m_hold = 0;
            return;
        end
        keep = (m_g >= 0) && rq[m_g];
        others = 0;
        for (int j = 0; j < N; j++)
            if (rq[j] && j != m_g) others = 1;
`ifdef ARB_HOLD_TIMEOUT_EN
        if (keep && m_hold == MAXH - 1 && others) keep = 0;
`endif
        if (keep) begin
            if (m_hold < MAXH - 1) m_hold++;
        end else begin
            w = -1;
            for (int i = 0; i < N; i++) begin
                int j;
                j = (m_ptr + i) % N;
                if (w < 0 && rq[j] && j != m_g) w = j;
            end
            m_hold = 0;
            if (w >= 0) begin
                m_g = w; m_s = w; m_ptr = (w + 1) % N;
            end else begin
                m_g = -1;
            end
        end
    endtask

    task automatic model_chk(input string tag);
        logic [3:0] eg;
        eg = (m_g < 0) ? 4'b0 : 4'(1 << m_g);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".s"}, 32'(s), 32'(m_s));
        chk({tag, ".busy"}, 32'(busy), 32'(m_g >= 0));
        chk({tag, ".out"}, 32'(out), 32'((m_g >= 0) && a[m_s]));
    endtask

    task automatic cyc(input logic r, input logic [3:0] rq,
                       input logic [3:0] av);
        rst = r; req = rq; a = av;
        @(posedge clk);
        model_step(r, rq);
        #1;
    endtask

    int order[5];
    int exp_order[5];
    logic [3:0] rq;

    initial begin
        rst = 1'b1; req = '0; a = '0;
        m_g = -1; m_s = 0; m_ptr = 0; m_hold = 0;

        tv[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
        tv[3]  = '{1'b0, 4'b1110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 4'b0100, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 4'b0100, 4'b1110, 4'b0100, 2'd2, 1'b1, 1'b1};
        tv[7]  = '{1'b0, 4'b0000, 4'b1110, 4'b0000, 2'd2, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        tv[9]  = '{1'b0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        tv[10] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
        tv[11] = '{1'b0, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0};
        tv[12] = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        tv[13] = '{1'b1, 4'b0100, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
        tv[14] = '{1'b0, 4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        tv[15] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};

        #2;
        chk("pre_reset_out", 32'(out), 32'(busy & a[s]));

        for (int k = 0; k < 16; k++) begin
            cyc(tv[k].rst, tv[k].req, tv[k].a);
            chk($sformatf("tv%0d.grant", k), 32'(grant), 32'(tv[k].g));
            chk($sformatf("tv%0d.s", k), 32'(s), 32'(tv[k].s));
            chk($sformatf("tv%0d.busy", k), 32'(busy), 32'(tv[k].b));
            chk($sformatf("tv%0d.out", k), 32'(out), 32'(tv[k].o));
        end

        // round robin: each grantee drops its request for one cycle
        cyc(1'b1, 4'b0000, 4'b0000);
        cyc(1'b1, 4'b0000, 4'b0000);
        exp_order = '{0, 1, 2, 3, 0};
        cyc(1'b0, 4'b1111, 4'b0101);
        model_chk("rr");
        order[0] = int'(s);
        for (int k = 1; k < 5; k++) begin
            cyc(1'b0, 4'b1111, 4'b0101);
            model_chk("rr");
            rq = 4'b1111;
            rq[order[k-1]] = 1'b0;
            cyc(1'b0, rq, 4'b0101);
            model_chk("rr");
            chk("rr.busy_no_gap", 32'(busy), 32'd1);
            order[k] = int'(s);
        end
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr.order%0d", k), 32'(order[k]),
                32'(exp_order[k]));

        // hold timeout: requester 0 holds, requester 2 waits
        cyc(1'b1, 4'b0000, 4'b0000);
        cyc(1'b0, 4'b0001, 4'b0001);
        model_chk("to");
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 4'b0101, 4'b0001);
            model_chk("to");
            if (i == 7)
                chk("to.still0", 32'(grant), 32'(4'b0001));
            if (i == 8) begin
`ifdef ARB_HOLD_TIMEOUT_EN
                chk("to.moved2", 32'(grant), 32'(4'b0100));
`else
                chk("to.stays0", 32'(grant), 32'(4'b0001));
`endif
            end
        end
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 4'b0101, 4'b0101);
            model_chk("to_tail");
        end

        // randomized traffic with occasional reset
        cyc(1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 63) == 0), 4'($urandom), 4'($urandom));
            model_chk("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
